board_mem_arbiter: RTL and testbench
====================================

# board_mem_arbiter

Arbiter and sequencer for the single-port game-board RAM (31 rows × 28 columns = 868 tile entries). It shares the RAM between three requesters: the tile renderer (the board scan that feeds video), the Pac-Man movement/pellet logic, and the ghost AI. It converts (x, y) tile coordinates to linear addresses and generates the two-cycle read timing. It also performs atomic read-modify-write for pellet eating.

## Interface
Parameters:
- COLS, 28, tiles per row
- ROWS, 31, tile rows
- DW, 4, tile code width
- RENDER_BURST, 3, max consecutive render grants while another requester waits

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- r_req  in  1  renderer read request; held until r_gnt
- r_x, r_y  in  5 each  renderer tile coordinates
- r_gnt  out  1  one-cycle grant; coordinates sampled this cycle
- r_valid  out  1  one-cycle pulse; r_data valid
- r_data  out  DW  tile read for renderer
- p_req  in  1  Pac-Man request; held until p_gnt
- p_we  in  1  1 = read-modify-write, 0 = read only
- p_x, p_y  in  5 each  Pac-Man tile coordinates
- p_wdata  in  DW  new tile value for RMW (sampled at grant)
- p_gnt  out  1  one-cycle grant
- p_valid  out  1  one-cycle pulse; p_rdata = pre-write value
- p_rdata  out  DW  tile read for Pac-Man
- g_req, g_x, g_y, g_gnt, g_valid, g_rdata  same as renderer, for ghost AI
- mem_en  out  1  RAM enable, active-high
- mem_we  out  1  RAM write enable
- mem_addr  out  10  linear address y*COLS + x
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data; valid when mem_en has been held for two cycles

## Operation
- States: IDLE, RD1, RD2, WR.
- Grants are issued only in IDLE, and at most one grant per cycle. The arbiter samples coordinates, p_we and p_wdata into registers at the grant.
- Priority is renderer > {Pac-Man, ghost}. Pac-Man and ghost alternate round-robin between themselves; the pointer flips after each grant to either of them. After reset the pointer favours Pac-Man.
- Starvation guard: a counter tracks consecutive render grants while p_req or g_req is pending. When the counter reaches RENDER_BURST, the next grant goes to the round-robin winner even if r_req is high. The counter clears on any non-render grant, and on any cycle in IDLE with neither p_req nor g_req pending.
- Address: mem_addr = y*28 + x, computed as (y<<4)+(y<<3)+(y<<2)+x at 10 bits.
- Out-of-range coordinates (x > 27 or y > 30):
  - The request is granted and sequenced normally, but mem_en stays 0 for the whole access.
  - The returned data is all ones (wall code).
  - An RMW to an out-of-range tile performs no write.
- State transitions:
  - IDLE → RD1 on any grant.
  - RD1 → RD2.
  - RD2 → WR if the access is a Pac-Man RMW; otherwise RD2 → IDLE.
  - WR → IDLE.
- In RD1 and RD2: mem_en = 1 (unless out of range), mem_we = 0, mem_addr held. mem_rdata is captured at the end of RD2.
- In WR: mem_en = 1, mem_we = 1 (unless out of range), same address, mem_wdata = the sampled p_wdata. No other access can interleave, so the RMW is atomic.
- Each *_data output holds its last value until that port's next valid pulse.

## Timing
- Reset values: state IDLE; all gnt, valid, mem_en and mem_we = 0; mem_addr = 0; mem_wdata = 0; all data outputs = 0; burst counter = 0; round-robin pointer favours Pac-Man.
- Read access:
  - Grant in cycle t (IDLE).
  - RD1 in t+1, RD2 in t+2.
  - *_valid in t+3, which is the IDLE cycle of the next arbitration. A new grant may also occur in t+3.
  - Throughput is one read per 3 cycles.
- RMW access:
  - Grant in t, RD1 in t+1, RD2 in t+2, WR in t+3.
  - p_valid in t+4 with the old tile value.
- Requests that arrive during a busy state wait. The arbiter never drops a held request.
- Reset mid-operation: the next cycle is IDLE. The in-flight access is abandoned with no valid pulse and no write; WR is suppressed if Reset is high in that cycle.

## Test plan
- Renderer only, (x=5, y=2): r_gnt at t, mem_addr=61 with mem_en=1 in t+1..t+2, RAM word 61 = 0x3 → r_valid at t+3 with r_data=0x3.
- Pac-Man RMW at (27, 30), p_wdata=0x0, RAM word 867 = 0x2: mem_we=1 with addr 867 in t+3, p_valid at t+4 with p_rdata=0x2, RAM word 867 = 0x0 afterwards.
- All three requests held continuously: grant order is R, R, R, P, R, R, R, G, R, R, R, P.
- Pac-Man and ghost only, both held: grants alternate P, G, P, G; no grant ever lands in RD1, RD2 or WR.
- Ghost read at (28, 0) and at (0, 31): mem_en stays 0, g_valid after 3 cycles with g_rdata=0xF; an RMW at (31, 31) leaves the RAM unchanged.
- Reset asserted during WR of an RMW: no write to RAM, no p_valid; IDLE and all outputs zero the next cycle; a request held through reset is granted in the first post-reset IDLE cycle.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Arbiter/sequencer for the single-port game-board RAM shared by renderer, Pac-Man and ghost AI.
// Two-cycle reads, atomic read-modify-write for Pac-Man, wall code returned for off-board tiles.
module board_mem_arbiter #(
  parameter int unsigned COLS         = 28,
  parameter int unsigned ROWS         = 31,
  parameter int unsigned DW           = 4,
  parameter int unsigned RENDER_BURST = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          r_req,
  input  logic [4:0]    r_x,
  input  logic [4:0]    r_y,
  output logic          r_gnt,
  output logic          r_valid,
  output logic [DW-1:0] r_data,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [4:0]    p_x,
  input  logic [4:0]    p_y,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_valid,
  output logic [DW-1:0] p_rdata,
  input  logic          g_req,
  input  logic [4:0]    g_x,
  input  logic [4:0]    g_y,
  output logic          g_gnt,
  output logic          g_valid,
  output logic [DW-1:0] g_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [9:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CntW = (RENDER_BURST < 1) ? 1 : $clog2(RENDER_BURST + 1);

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StWr} state_e;
  typedef enum logic [1:0] {OwnRend, OwnPac, OwnGhost} owner_e;

  state_e          r_state, w_state_d;
  owner_e          r_owner;
  logic            r_rmw, r_oor, r_rr_ghost;
  logic [CntW-1:0] r_burst;
  logic [9:0]      r_addr;
  logic [DW-1:0]   r_wdata, r_rbuf;

  logic            w_idle, w_pg_pend, w_pick_ghost, w_burst_full;
  logic            w_gnt_r, w_gnt_p, w_gnt_g, w_any_gnt, w_sel_oor;
  logic [4:0]      w_sel_x, w_sel_y;
  logic [9:0]      w_y10, w_sel_addr;
  logic [DW-1:0]   w_rd_val;

  always_comb begin
    w_idle       = (r_state == StIdle) && !Reset;
    w_pg_pend    = p_req || g_req;
    // Round-robin winner between Pac-Man and ghost; falls to whichever is actually requesting.
    w_pick_ghost = r_rr_ghost ? g_req : !p_req;
    w_burst_full = (r_burst >= CntW'(RENDER_BURST));
    w_gnt_r      = w_idle && r_req && !(w_pg_pend && w_burst_full);
    w_gnt_p      = w_idle && w_pg_pend && !w_gnt_r && !w_pick_ghost;
    w_gnt_g      = w_idle && w_pg_pend && !w_gnt_r && w_pick_ghost;
    w_any_gnt    = w_gnt_r || w_gnt_p || w_gnt_g;

    w_sel_x = w_gnt_r ? r_x : (w_gnt_p ? p_x : g_x);
    w_sel_y = w_gnt_r ? r_y : (w_gnt_p ? p_y : g_y);
    // y*28 + x as shift-add; the board width is fixed at 28 by the address map.
    w_y10      = {5'd0, w_sel_y};
    w_sel_addr = (w_y10 << 4) + (w_y10 << 3) + (w_y10 << 2) + {5'd0, w_sel_x};
    w_sel_oor  = ({1'b0, w_sel_x} >= 6'(COLS)) || ({1'b0, w_sel_y} >= 6'(ROWS));
    w_rd_val   = r_oor ? '1 : mem_rdata;

    r_gnt = w_gnt_r;
    p_gnt = w_gnt_p;
    g_gnt = w_gnt_g;

    mem_en    = !Reset && (r_state != StIdle) && !r_oor;
    mem_we    = !Reset && (r_state == StWr) && !r_oor;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_gnt) w_state_d = StRd1;
      StRd1:   w_state_d = StRd2;
      StRd2:   w_state_d = r_rmw ? StWr : StIdle;
      StWr:    w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_owner    <= OwnRend;
      r_rmw      <= 1'b0;
      r_oor      <= 1'b0;
      r_rr_ghost <= 1'b0;
      r_burst    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_valid    <= 1'b0;
      p_valid    <= 1'b0;
      g_valid    <= 1'b0;
      r_data     <= '0;
      p_rdata    <= '0;
      g_rdata    <= '0;
    end else begin
      r_valid <= 1'b0;
      p_valid <= 1'b0;
      g_valid <= 1'b0;

      if (w_gnt_p || w_gnt_g)                  r_burst <= '0;
      else if (w_gnt_r)                        r_burst <= w_pg_pend ? r_burst + CntW'(1) : '0;
      else if (r_state == StIdle && !w_pg_pend) r_burst <= '0;

      if (w_gnt_p)      r_rr_ghost <= 1'b1;
      else if (w_gnt_g) r_rr_ghost <= 1'b0;

      if (w_any_gnt) begin
        r_owner <= w_gnt_r ? OwnRend : (w_gnt_p ? OwnPac : OwnGhost);
        r_rmw   <= w_gnt_p && p_we;
        r_oor   <= w_sel_oor;
        r_addr  <= w_sel_addr;
      end
      if (w_gnt_p) r_wdata <= p_wdata;

      if (r_state == StRd2) begin
        r_rbuf <= w_rd_val;
        if (!r_rmw) begin
          unique case (r_owner)
            OwnRend:  begin r_valid <= 1'b1; r_data  <= w_rd_val; end
            OwnPac:   begin p_valid <= 1'b1; p_rdata <= w_rd_val; end
            OwnGhost: begin g_valid <= 1'b1; g_rdata <= w_rd_val; end
            default: ;
          endcase
        end
      end
      // RMW reports the pre-write value once the write cycle has completed.
      if (r_state == StWr) begin
        p_valid <= 1'b1;
        p_rdata <= r_rbuf;
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomized and directed bench for board_mem_arbiter against a cycle-budget reference model.
module tb_board_mem_arbiter;
  localparam int unsigned DW = 4;
  localparam int RenderBurst = 3;

  logic Clk, Reset;
  logic r_req, p_req, g_req, p_we;
  logic [4:0] r_x, r_y, p_x, p_y, g_x, g_y;
  logic [DW-1:0] p_wdata;
  logic r_gnt, r_valid, p_gnt, p_valid, g_gnt, g_valid, mem_en, mem_we;
  logic [DW-1:0] r_data, p_rdata, g_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;

  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rd_pipe;
  logic poke_en;
  logic [9:0] poke_addr;
  logic [DW-1:0] poke_data;

  int n_vec, n_err;
  int cyc, free_cyc, burst, acc_t, acc_who, acc_addr, vcyc, mode;
  bit fav_g, acc_on, acc_rmw, acc_oor, vpend;
  logic [DW-1:0] acc_wd, acc_rd;
  logic [DW-1:0] hold [3];
  logic [DW-1:0] ref_mem [1024];
  bit got_g [3];
  int gnt_log [$];

  board_mem_arbiter #(.COLS(28), .ROWS(31), .DW(DW), .RENDER_BURST(RenderBurst)) dut (
    .Clk(Clk), .Reset(Reset),
    .r_req(r_req), .r_x(r_x), .r_y(r_y), .r_gnt(r_gnt), .r_valid(r_valid), .r_data(r_data),
    .p_req(p_req), .p_we(p_we), .p_x(p_x), .p_y(p_y), .p_wdata(p_wdata), .p_gnt(p_gnt),
    .p_valid(p_valid), .p_rdata(p_rdata),
    .g_req(g_req), .g_x(g_x), .g_y(g_y), .g_gnt(g_gnt), .g_valid(g_valid), .g_rdata(g_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM: data read on one enabled edge is presented for the following cycle.
  assign mem_rdata = rd_pipe;
  always @(posedge Clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en) rd_pipe <= ram[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int i, input bit any_coord, input bit allow_we);
    logic [4:0] x, y;
    x = any_coord ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 27));
    y = any_coord ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 30));
    case (i)
      0: begin r_req = 1'b1; r_x = x; r_y = y; end
      1: begin
        p_req = 1'b1; p_x = x; p_y = y;
        p_we = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
        p_wdata = 4'($urandom_range(0, 15));
      end
      default: begin g_req = 1'b1; g_x = x; g_y = y; end
    endcase
  endtask

  task automatic drive();
    bit pend;
    if (got_g[0]) r_req = 1'b0;
    if (got_g[1]) p_req = 1'b0;
    if (got_g[2]) g_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend = (i == 0) ? r_req : ((i == 1) ? p_req : g_req);
      case (mode)
        1: if (!pend && $urandom_range(0, 2) == 0) new_req(i, 1'b1, 1'b1);
        2: if (!pend) new_req(i, 1'b0, 1'b0);
        3: if (!pend && i != 0) new_req(i, 1'b0, 1'b0);
        default: ;
      endcase
    end
  endtask

  // Reference: an access occupies the RAM for 3 cycles (read) or 4 (RMW) from its grant.
  task automatic check_cycle();
    logic [2:0] eg, ev, ag;
    bit pg, e_en, e_we;
    int len, x, y;
    eg = '0;
    ev = '0;
    pg = p_req || g_req;
    if (vpend && cyc == vcyc) begin
      ev[acc_who] = 1'b1;
      hold[acc_who] = acc_rd;
      vpend = 1'b0;
    end
    len = acc_rmw ? 3 : 2;
    e_en = acc_on && !Reset && (cyc > acc_t) && (cyc <= acc_t + len) && !acc_oor;
    e_we = e_en && acc_rmw && (cyc == acc_t + 3);
    if (!Reset && cyc >= free_cyc) begin
      if (r_req && !(pg && burst >= RenderBurst)) eg = 3'b001;
      else if (pg) eg = ((fav_g && g_req) || !p_req) ? 3'b100 : 3'b010;
    end
    ag = {g_gnt, p_gnt, r_gnt};
    check_val("gnt{g,p,r}", 32'(ag), 32'(eg));
    check_val("valid{g,p,r}", 32'({g_valid, p_valid, r_valid}), 32'(ev));
    check_val("r_data", 32'(r_data), 32'(hold[0]));
    check_val("p_rdata", 32'(p_rdata), 32'(hold[1]));
    check_val("g_rdata", 32'(g_rdata), 32'(hold[2]));
    check_val("mem_en_we", 32'({mem_en, mem_we}), 32'({e_en, e_we}));
    if (e_en) check_val("mem_addr", 32'(mem_addr), 32'(acc_addr));
    if (e_we) check_val("mem_wdata", 32'(mem_wdata), 32'(acc_wd));
    for (int i = 0; i < 3; i++) begin
      got_g[i] = ag[i];
      if (ag[i]) gnt_log.push_back(i);
    end
    if (Reset) begin
      acc_on = 1'b0; vpend = 1'b0; free_cyc = cyc + 1; burst = 0; fav_g = 1'b0;
      for (int i = 0; i < 3; i++) hold[i] = '0;
    end else begin
      if (e_we) ref_mem[acc_addr] = acc_wd;
      if (eg[1] || eg[2]) burst = 0;
      else if (eg[0]) burst = pg ? burst + 1 : 0;
      else if (cyc >= free_cyc && !pg) burst = 0;
      if (eg != 3'b000) begin
        acc_who = eg[0] ? 0 : (eg[1] ? 1 : 2);
        x = (acc_who == 0) ? int'(r_x) : ((acc_who == 1) ? int'(p_x) : int'(g_x));
        y = (acc_who == 0) ? int'(r_y) : ((acc_who == 1) ? int'(p_y) : int'(g_y));
        acc_oor  = (x > 27) || (y > 30);
        acc_addr = y * 28 + x;
        acc_rd   = acc_oor ? 4'hF : ref_mem[acc_addr];
        acc_rmw  = (acc_who == 1) && p_we;
        acc_wd   = p_wdata;
        acc_t    = cyc;
        acc_on   = 1'b1;
        free_cyc = cyc + (acc_rmw ? 4 : 3);
        vcyc     = free_cyc;
        vpend    = 1'b1;
        if (acc_who == 1) fav_g = 1'b1;
        else if (acc_who == 2) fav_g = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge Clk);
    check_cycle();
    @(posedge Clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    mode = 0;
    for (int k = 0; k < 60; k++) begin
      if (!r_req && !p_req && !g_req && cyc > free_cyc) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_val("drain_done", 32'(ok), 32'd1);
  endtask

  task automatic wait_gnt(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (got_g[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("gnt_wait", 32'(ok), 32'd1);
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_addr = 10'(a); poke_data = d;
    ref_mem[a] = d;
    step();
    poke_en = 1'b0;
  endtask

  initial begin
    int base, old87;
    int exp_ord [12];
    logic [DW-1:0] d;
    exp_ord = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 1};
    n_vec = 0; n_err = 0; mode = 0; cyc = 0;
    Reset = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    r_req = 0; p_req = 0; g_req = 0; p_we = 0; p_wdata = '0;
    r_x = '0; r_y = '0; p_x = '0; p_y = '0; g_x = '0; g_y = '0;

    // Fill the RAM while the DUT is held in reset.
    for (int i = 0; i < 1024; i++) begin
      d = 4'($urandom_range(0, 15));
      poke_en = 1'b1; poke_addr = 10'(i); poke_data = d;
      ref_mem[i] = d;
      @(posedge Clk);
      #1;
    end
    poke_en = 1'b0;

    @(negedge Clk);
    check_val("rst_gnt", 32'({g_gnt, p_gnt, r_gnt}), 32'd0);
    check_val("rst_valid", 32'({g_valid, p_valid, r_valid}), 32'd0);
    check_val("rst_r_data", 32'(r_data), 32'd0);
    check_val("rst_p_rdata", 32'(p_rdata), 32'd0);
    check_val("rst_g_rdata", 32'(g_rdata), 32'd0);
    check_val("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    free_cyc = 0; burst = 0; fav_g = 0; acc_on = 0; vpend = 0; acc_rmw = 0;
    for (int i = 0; i < 3; i++) hold[i] = '0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // All three requesters held continuously.
    mode = 2;
    drive();
    for (int k = 0; k < 200 && gnt_log.size() < 12; k++) step();
    check_val("order_count", 32'(gnt_log.size() >= 12), 32'd1);
    for (int k = 0; k < 12 && k < gnt_log.size(); k++)
      check_val($sformatf("order[%0d]", k), 32'(gnt_log[k]), 32'(exp_ord[k]));
    drain();

    // Renderer read at (5,2) -> word 61.
    poke(61, 4'h3);
    r_req = 1'b1; r_x = 5'd5; r_y = 5'd2;
    wait_gnt(0);
    repeat (4) step();
    check_val("rend_5_2", 32'(r_data), 32'h3);

    // Pac-Man RMW at (27,30) -> word 867.
    poke(867, 4'h2);
    p_req = 1'b1; p_x = 5'd27; p_y = 5'd30; p_we = 1'b1; p_wdata = 4'h0;
    wait_gnt(1);
    repeat (5) step();
    check_val("pac_rmw_old", 32'(p_rdata), 32'h2);
    check_val("ram_867_after", 32'(ram[867]), 32'h0);
    drain();

    // Pac-Man and ghost only: grants must alternate.
    base = gnt_log.size();
    mode = 3;
    drive();
    for (int k = 0; k < 100 && gnt_log.size() < base + 8; k++) step();
    check_val("pg_count", 32'(gnt_log.size() >= base + 8), 32'd1);
    for (int k = base + 1; k < base + 8 && k < gnt_log.size(); k++)
      check_val("pg_alternate", 32'(gnt_log[k] + gnt_log[k-1]), 32'd3);
    drain();

    // Off-board tiles return the wall code and never touch the RAM.
    g_req = 1'b1; g_x = 5'd28; g_y = 5'd0;
    wait_gnt(2);
    repeat (4) step();
    check_val("ghost_28_0", 32'(g_rdata), 32'hF);
    g_req = 1'b1; g_x = 5'd0; g_y = 5'd31;
    wait_gnt(2);
    repeat (4) step();
    check_val("ghost_0_31", 32'(g_rdata), 32'hF);
    p_req = 1'b1; p_x = 5'd31; p_y = 5'd31; p_we = 1'b1; p_wdata = 4'h5;
    wait_gnt(1);
    repeat (5) step();
    check_val("pac_rmw_oor", 32'(p_rdata), 32'hF);
    drain();

    mode = 1;
    repeat (3000) step();
    drain();

    // Reset during the write cycle of an RMW, with a second request held through it.
    old87 = int'(ref_mem[87]);
    p_req = 1'b1; p_x = 5'd3; p_y = 5'd3; p_we = 1'b1; p_wdata = ref_mem[87] ^ 4'h5;
    wait_gnt(1);
    p_req = 1'b1; p_x = 5'd5; p_y = 5'd5; p_we = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    step();
    check_val("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mid_mem_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_mid_p_rdata", 32'(p_rdata), 32'd0);
    check_val("rst_mid_mem_en", 32'(mem_en), 32'd0);
    Reset = 1'b0;
    step();
    check_val("post_rst_gnt", 32'(got_g[1]), 32'd1);
    repeat (4) step();
    check_val("post_rst_data", 32'(p_rdata), 32'(ref_mem[145]));
    check_val("rst_no_write", 32'(ram[87]), 32'(old87));
    drain();

    for (int i = 0; i < 1024; i++) check_val($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
